// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search sequencer: FSM states,
// S RAM owner encoding and the plaintext character-class test.
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_GO,
        ST_INIT_WAIT,
        ST_KSA_GO,
        ST_KSA_WAIT,
        ST_DEC_GO,
        ST_DEC_WAIT,
        ST_CHECK,
        ST_NEXT_KEY,
        ST_FOUND,
        ST_EXHAUSTED
    } state_t;

    // Encoding matters: the arbiter maps requester index i to owner value i+1.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INIT = 2'd1,
        OWN_KSA  = 2'd2,
        OWN_DEC  = 2'd3
    } owner_t;

    localparam logic [7:0] ASCII_LO    = 8'h61;
    localparam logic [7:0] ASCII_HI    = 8'h7A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam int         S_ADDR_W    = 8;

    function automatic logic is_text(input logic [7:0] b);
        return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SPACE);
    endfunction

    function automatic owner_t owner_of(input state_t s);
        case (s)
            ST_INIT_GO, ST_INIT_WAIT: return OWN_INIT;
            ST_KSA_GO,  ST_KSA_WAIT:  return OWN_KSA;
            ST_DEC_GO,  ST_DEC_WAIT:  return OWN_DEC;
            default:                  return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rc4_s_ram_arbiter.sv
// Single-port S RAM mux: forwards the owning requester's address/data/wren
// and forces everything to zero when no phase owns the RAM.
module rc4_s_ram_arbiter
    import rc4_pkg::*;
(
    input  logic [1:0]          owner,
    input  logic [S_ADDR_W-1:0] init_s_addr,
    input  logic [7:0]          init_s_data,
    input  logic                init_s_wren,
    input  logic [S_ADDR_W-1:0] ksa_s_addr,
    input  logic [7:0]          ksa_s_data,
    input  logic                ksa_s_wren,
    input  logic [S_ADDR_W-1:0] dec_s_addr,
    input  logic [7:0]          dec_s_data,
    input  logic                dec_s_wren,
    output logic [S_ADDR_W-1:0] s_addr,
    output logic [7:0]          s_data,
    output logic                s_wren
);

    logic [S_ADDR_W-1:0] addr_in [3];
    logic [7:0]          data_in [3];
    logic [2:0]          wren_in;
    logic [S_ADDR_W-1:0] addr_m  [3];
    logic [7:0]          data_m  [3];
    logic [2:0]          wren_m;
    logic [2:0]          sel;

    assign addr_in[0] = init_s_addr;
    assign addr_in[1] = ksa_s_addr;
    assign addr_in[2] = dec_s_addr;
    assign data_in[0] = init_s_data;
    assign data_in[1] = ksa_s_data;
    assign data_in[2] = dec_s_data;
    assign wren_in    = {dec_s_wren, ksa_s_wren, init_s_wren};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_req
            assign sel[gi]    = (owner == 2'(gi + 1));
            assign addr_m[gi] = sel[gi] ? addr_in[gi] : '0;
            assign data_m[gi] = sel[gi] ? data_in[gi] : '0;
            assign wren_m[gi] = sel[gi] & wren_in[gi];
        end
    endgenerate

    // At most one select is hot, so OR-ing the gated lanes is a clean mux.
    assign s_addr = addr_m[0] | addr_m[1] | addr_m[2];
    assign s_data = data_m[0] | data_m[1] | data_m[2];
    assign s_wren = |wren_m;

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// RC4 brute-force sequencer: runs init -> KSA -> decrypt per candidate key,
// snoops decrypted bytes, and stops on printable-lowercase plaintext or KEY_MAX.
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                  MESSAGE_LENGTH = 32,
    parameter int                  KEY_BITS       = 24,
    parameter logic [KEY_BITS-1:0] KEY_MIN        = 24'h000000,
    parameter logic [KEY_BITS-1:0] KEY_MAX        = 24'h3FFFFF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic [KEY_BITS-1:0] key,
    output logic                init_start,
    output logic                ksa_start,
    output logic                dec_start,
    input  logic                init_finish,
    input  logic                ksa_finish,
    input  logic                dec_finish,
    input  logic [7:0]          init_s_addr,
    input  logic [7:0]          ksa_s_addr,
    input  logic [7:0]          dec_s_addr,
    input  logic [7:0]          init_s_data,
    input  logic [7:0]          ksa_s_data,
    input  logic [7:0]          dec_s_data,
    input  logic                init_s_wren,
    input  logic                ksa_s_wren,
    input  logic                dec_s_wren,
    output logic [7:0]          s_addr,
    output logic [7:0]          s_data,
    output logic                s_wren,
    input  logic                dec_wren,
    input  logic [7:0]          dec_data,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic [KEY_BITS-1:0] found_key
);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [KEY_BITS-1:0] found_key_q, found_key_d;
    logic [7:0]          count_q, count_d;
    logic                bad_q, bad_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            key_q       <= KEY_MIN;
            found_key_q <= '0;
            count_q     <= '0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            key_q       <= key_d;
            found_key_q <= found_key_d;
            count_q     <= count_d;
            bad_q       <= bad_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        found_key_d = found_key_q;
        count_d     = count_q;
        bad_d       = bad_q;
        case (state_q)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                if (start) begin
                    state_d = ST_INIT_GO;
                    key_d   = KEY_MIN;
                end
            end
            ST_INIT_GO:   state_d = ST_INIT_WAIT;
            ST_INIT_WAIT: if (init_finish) state_d = ST_KSA_GO;
            ST_KSA_GO:    state_d = ST_KSA_WAIT;
            ST_KSA_WAIT:  if (ksa_finish) state_d = ST_DEC_GO;
            ST_DEC_GO: begin
                count_d = '0;
                bad_d   = 1'b0;
                state_d = ST_DEC_WAIT;
            end
            ST_DEC_WAIT: begin
                // A write landing with dec_finish is still folded in before CHECK.
                if (dec_wren) begin
                    count_d = count_q + 8'd1;
                    if (!is_text(dec_data)) bad_d = 1'b1;
                end
                if (dec_finish) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (!bad_q && (count_q == 8'(MESSAGE_LENGTH))) begin
                    state_d     = ST_FOUND;
                    found_key_d = key_q;
                end else begin
                    state_d = ST_NEXT_KEY;
                end
            end
            ST_NEXT_KEY: begin
                if (key_q == KEY_MAX) begin
                    state_d = ST_EXHAUSTED;
                end else begin
                    key_d   = key_q + KEY_BITS'(1);
                    state_d = ST_INIT_GO;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        owner_d = owner_of(state_d);
    end

    assign key        = key_q;
    assign found_key  = found_key_q;
    assign init_start = (state_q == ST_INIT_GO);
    assign ksa_start  = (state_q == ST_KSA_GO);
    assign dec_start  = (state_q == ST_DEC_GO);
    assign found      = (state_q == ST_FOUND);
    assign exhausted  = (state_q == ST_EXHAUSTED);
    assign busy       = !((state_q == ST_IDLE) || (state_q == ST_FOUND) ||
                          (state_q == ST_EXHAUSTED));

    rc4_s_ram_arbiter u_arb (
        .owner       (owner_q),
        .init_s_addr (init_s_addr),
        .init_s_data (init_s_data),
        .init_s_wren (init_s_wren),
        .ksa_s_addr  (ksa_s_addr),
        .ksa_s_data  (ksa_s_data),
        .ksa_s_wren  (ksa_s_wren),
        .dec_s_addr  (dec_s_addr),
        .dec_s_data  (dec_s_data),
        .dec_s_wren  (dec_s_wren),
        .s_addr      (s_addr),
        .s_data      (s_data),
        .s_wren      (s_wren)
    );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: stub sub-FSMs with fixed latencies, a key-level
// search model, a per-cycle S RAM port checker and hand-computed outcome pins.
module tb_rc4_key_search_ctrl;

    localparam logic [23:0] KMIN = 24'h000000;
    localparam logic [23:0] KMAX = 24'h000007;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [23:0] key, found_key;
    logic        init_start, ksa_start, dec_start;
    logic        init_finish, ksa_finish, dec_finish;
    logic [7:0]  init_s_addr, ksa_s_addr, dec_s_addr;
    logic [7:0]  init_s_data, ksa_s_data, dec_s_data;
    logic        init_s_wren, ksa_s_wren, dec_s_wren;
    logic [7:0]  s_addr, s_data;
    logic        s_wren;
    logic        dec_wren;
    logic [7:0]  dec_data;
    logic        busy, found, exhausted;

    always #5 clock = ~clock;

    rc4_key_search_ctrl #(
        .MESSAGE_LENGTH (32),
        .KEY_BITS       (24),
        .KEY_MIN        (KMIN),
        .KEY_MAX        (KMAX)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .key         (key),
        .init_start  (init_start),
        .ksa_start   (ksa_start),
        .dec_start   (dec_start),
        .init_finish (init_finish),
        .ksa_finish  (ksa_finish),
        .dec_finish  (dec_finish),
        .init_s_addr (init_s_addr),
        .ksa_s_addr  (ksa_s_addr),
        .dec_s_addr  (dec_s_addr),
        .init_s_data (init_s_data),
        .ksa_s_data  (ksa_s_data),
        .dec_s_data  (dec_s_data),
        .init_s_wren (init_s_wren),
        .ksa_s_wren  (ksa_s_wren),
        .dec_s_wren  (dec_s_wren),
        .s_addr      (s_addr),
        .s_data      (s_data),
        .s_wren      (s_wren),
        .dec_wren    (dec_wren),
        .dec_data    (dec_data),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .found_key   (found_key)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;
    int cyc      = 0;
    int act      = 0;   // 0 none, 1 init, 2 ksa, 3 dec: which stub is mid-phase
    int init_cnt = -1, ksa_cnt = -1, dec_cnt = -1, dec_len = 0;
    int init_pulses = 0, ksa_pulses = 0, dec_pulses = 0, dup_pulses = 0;
    logic [23:0] dec_key = '0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Plaintext generators per test mode, indexed by key and byte position.
    function automatic int nbytes(input int m, input int k);
        if (m == 3 && k == 0) return 31;
        if (m == 1 && k == 4) return 33;
        return 32;
    endfunction

    function automatic logic [7:0] byte_of(input int m, input int k, input int i);
        case (m)
            0: return 8'h61;
            1: begin
                if (k == 5) begin
                    if (i % 3 == 0) return 8'h20;
                    if (i % 3 == 1) return 8'h61;
                    return 8'h7A;
                end
                if (k == 2) return 8'h60;
                if (k == 3) return (i == 31) ? 8'h7B : 8'h7A;
                if (k == 4) return 8'h62;
                return 8'h41;
            end
            2: return 8'h7B;
            default: return 8'h61;
        endcase
    endfunction

    function automatic bit key_ok(input int m, input int k);
        logic [7:0] b;
        if (nbytes(m, k) != 32) return 1'b0;
        for (int i = 0; i < 32; i++) begin
            b = byte_of(m, k, i);
            if (!((b >= 8'h61 && b <= 8'h7A) || b == 8'h20)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Stub sub-FSMs: each finishes 3 cycles after its start; decrypt streams bytes.
    initial begin
        init_finish = 0; ksa_finish = 0; dec_finish = 0; dec_wren = 0; dec_data = 0;
        init_s_addr = 0; init_s_data = 0; init_s_wren = 0;
        ksa_s_addr = 0; ksa_s_data = 0; ksa_s_wren = 0;
        dec_s_addr = 0; dec_s_data = 0; dec_s_wren = 0;
        forever begin
            @(negedge clock);
            cyc++;
            init_finish = 0; ksa_finish = 0; dec_finish = 0;
            dec_wren = 0; dec_data = 8'h00;
            init_s_addr = 8'(cyc); init_s_data = ~8'(cyc); init_s_wren = (cyc % 2 == 1);
            ksa_s_addr = 8'hA5; ksa_s_data = 8'h5A; ksa_s_wren = 1'b1;
            dec_s_addr = 8'h3C ^ 8'(cyc); dec_s_data = 8'hC3; dec_s_wren = 1'b1;
            act = 0;
            if (reset) begin
                init_cnt = -1; ksa_cnt = -1; dec_cnt = -1;
            end else begin
                if (init_start) begin
                    if (init_cnt >= 0) dup_pulses++;
                    init_cnt = 0; init_pulses++;
                end else if (init_cnt >= 0) init_cnt++;
                if (ksa_start) begin
                    if (ksa_cnt >= 0) dup_pulses++;
                    ksa_cnt = 0; ksa_pulses++;
                end else if (ksa_cnt >= 0) ksa_cnt++;
                if (dec_start) begin
                    if (dec_cnt >= 0) dup_pulses++;
                    dec_cnt = 0; dec_pulses++;
                    dec_key = key; dec_len = nbytes(mode, int'(key));
                    dec_wren = 1'b1; dec_data = 8'h00;  // stray write in DEC_GO
                end else if (dec_cnt >= 0) dec_cnt++;

                if (init_cnt >= 0) begin
                    act = 1;
                    if (init_cnt == 3) begin init_finish = 1; init_cnt = -1; end
                end
                if (ksa_cnt >= 0) begin
                    act = 2;
                    if (ksa_cnt == 1) begin init_finish = 1; dec_finish = 1; end
                    if (ksa_cnt == 3) begin ksa_finish = 1; ksa_cnt = -1; end
                end
                if (dec_cnt >= 0) begin
                    act = 3;
                    if (dec_cnt >= 1 && dec_cnt <= dec_len) begin
                        dec_wren = 1'b1;
                        dec_data = byte_of(mode, int'(dec_key), dec_cnt - 1);
                    end
                    if (dec_cnt == dec_len) begin dec_finish = 1; dec_cnt = -1; end
                end
            end
        end
    end

    // Per-cycle checker: S RAM port must carry exactly the active stub's request.
    initial begin
        logic [7:0] ea, ed;
        logic       ew;
        forever begin
            @(negedge clock);
            #2;
            if (!reset && check_en) begin
                ea = 8'h00; ed = 8'h00; ew = 1'b0;
                if (act == 1) begin ea = init_s_addr; ed = init_s_data; ew = init_s_wren; end
                if (act == 2) begin ea = ksa_s_addr;  ed = ksa_s_data;  ew = ksa_s_wren;  end
                if (act == 3) begin ea = dec_s_addr;  ed = dec_s_data;  ew = dec_s_wren;  end
                chk("s_addr", 32'(s_addr), 32'(ea));
                chk("s_data", 32'(s_data), 32'(ed));
                chk("s_wren", 32'(s_wren), 32'(ew));
                if (act != 0) begin
                    chk("busy_in_phase", 32'(busy), 32'd1);
                    chk("found_in_phase", 32'(found), 32'd0);
                    chk("exhausted_in_phase", 32'(exhausted), 32'd0);
                end
                if (init_start || ksa_start)
                    chk("key_in_pass", 32'(key), 32'(KMIN) + 32'(init_pulses - 1));
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_found"}, 32'(found), 32'd0);
        chk({tag, "_exhausted"}, 32'(exhausted), 32'd0);
        chk({tag, "_key"}, 32'(key), 32'h0);
        chk({tag, "_found_key"}, 32'(found_key), 32'h0);
        chk({tag, "_starts"}, {29'd0, init_start, ksa_start, dec_start}, 32'd0);
        chk({tag, "_s_wren"}, 32'(s_wren), 32'd0);
        chk({tag, "_s_addr"}, 32'(s_addr), 32'd0);
        chk({tag, "_s_data"}, 32'(s_data), 32'd0);
    endtask

    task automatic kick(input int m);
        @(negedge clock); #3;
        mode = m;
        init_pulses = 0; ksa_pulses = 0; dec_pulses = 0; dup_pulses = 0;
        start = 1'b1;
        @(negedge clock); #3;
        start = 1'b0;
    endtask

    task automatic run_search(input int m, input bit lit_found, input int lit_key, input int lit_passes);
        int  passes, ek;
        bit  ef, done;
        passes = 0; ef = 1'b0; ek = int'(KMAX);
        for (int k = int'(KMIN); k <= int'(KMAX); k++) begin
            passes++;
            if (key_ok(m, k)) begin ef = 1'b1; ek = k; break; end
        end
        kick(m);
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock); #3;
            start = (m == 1 && i == 60);   // start while busy must be ignored
            if ((found || exhausted) && !busy) done = 1'b1;
        end
        start = 1'b0;
        chk("search_done", 32'(done), 32'd1);
        chk("found", 32'(found), 32'(ef));
        chk("exhausted", 32'(exhausted), 32'(!ef));
        chk("final_key", 32'(key), 32'(ek));
        if (ef) chk("found_key", 32'(found_key), 32'(ek));
        chk("init_pulses", 32'(init_pulses), 32'(passes));
        chk("ksa_pulses", 32'(ksa_pulses), 32'(passes));
        chk("dec_pulses", 32'(dec_pulses), 32'(passes));
        chk("dup_pulses", 32'(dup_pulses), 32'd0);
        chk("lit_found", 32'(found), 32'(lit_found));
        chk("lit_key", 32'(key), 32'(lit_key));
        chk("lit_passes", 32'(init_pulses), 32'(lit_passes));
        repeat (3) @(negedge clock);
        #3;
        chk("result_held", {30'd0, found, exhausted}, {30'd0, ef, !ef});
        $display("search mode %0d: found=%0d exhausted=%0d key=%0h found_key=%0h passes=%0d",
                 m, found, exhausted, key, found_key, init_pulses);
    endtask

    initial begin
        bit reached;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        #3;
        check_reset("reset");
        reset = 1'b0;
        check_en = 1'b1;

        run_search(0, 1'b1, 0, 1);
        run_search(1, 1'b1, 5, 6);
        run_search(2, 1'b0, 7, 8);
        run_search(3, 1'b1, 1, 2);

        kick(0);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clock); #3;
            if (ksa_cnt == 1) reached = 1'b1;
        end
        chk("reach_ksa_wait", 32'(reached), 32'd1);
        reset = 1'b1;
        @(negedge clock); #3;
        check_reset("midpass_reset");
        $display("mid-pass reset applied: busy=%0d key=%0h", busy, key);
        reset = 1'b0;

        run_search(0, 1'b1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_key_search_ctrl.md
# rc4_key_search_ctrl

Top-level sequencer for the RC4 brute-force key search. Drives the three datapath FSMs (S-array init, key-schedule swap, PRGA decrypt) in order through start/finish pulses, arbitrates the single-port S RAM between them, and checks every decrypted byte as it is written. Increments the candidate key after each failed pass and stops on the first plaintext that is all lowercase or space, or when the key range is exhausted.

## Interface
Parameters:
- MESSAGE_LENGTH, 32, decrypted bytes expected per pass
- KEY_BITS, 24, candidate key width
- KEY_MIN, 24'h000000, first key tried
- KEY_MAX, 24'h3FFFFF, last key tried (inclusive)

Ports:
- clock  in  1  single system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin search from KEY_MIN; sampled only in IDLE, FOUND, EXHAUSTED
- key  out  KEY_BITS  current candidate key, fed to key-schedule FSM
- init_start / ksa_start / dec_start  out  1 each  one-cycle start pulses
- init_finish / ksa_finish / dec_finish  in  1 each  one-cycle finish pulses
- init_s_addr, ksa_s_addr, dec_s_addr  in  8 each  requester S RAM address
- init_s_data, ksa_s_data, dec_s_data  in  8 each  requester S RAM write data
- init_s_wren, ksa_s_wren, dec_s_wren  in  1 each  requester S RAM write enable
- s_addr  out  8, s_data  out  8, s_wren  out  1  arbitrated S RAM port
- dec_wren  in  1, dec_data  in  8  decrypt FSM writes to decrypted RAM (snooped)
- busy  out  1  search in progress
- found  out  1  valid key found; held until next start/reset
- exhausted  out  1  KEY_MAX failed; held until next start/reset
- found_key  out  KEY_BITS  key that produced valid plaintext

## Operation
- States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, DEC_GO, DEC_WAIT, CHECK, NEXT_KEY, FOUND, EXHAUSTED.
- IDLE/FOUND/EXHAUSTED + start -> INIT_GO; key <= KEY_MIN, found/exhausted cleared.
- X_GO: assert X_start one cycle -> X_WAIT. X_WAIT: hold until X_finish -> next phase (INIT->KSA_GO, KSA->DEC_GO, DEC->CHECK).
- DEC_GO also clears bad flag and byte counter (8 bits).
- DEC_WAIT: each cycle dec_wren=1 -> count+1; if dec_data not in 8'h61..8'h7A and not 8'h20 -> bad<=1.
- CHECK: pass iff bad==0 and count==MESSAGE_LENGTH -> FOUND (found_key<=key); else NEXT_KEY.
- NEXT_KEY: key==KEY_MAX -> EXHAUSTED; else key<=key+1 -> INIT_GO. Increment is KEY_BITS wide, no wrap.
- Owner register: INIT in INIT_GO/INIT_WAIT, KSA in KSA_*, DEC in DEC_*, NONE elsewhere. s_* = owner's inputs combinationally; NONE -> s_addr=0, s_data=0, s_wren=0. Non-owner wren always masked.
- Finish pulses from a non-waited FSM, and dec_wren outside DEC_WAIT, are ignored.

## Timing
- Reset: state IDLE, key=KEY_MIN, found_key=0, all start pulses 0, busy=found=exhausted=0, s_wren=0, s_addr=s_data=0, count=0, bad=0. Reset mid-pass aborts immediately; sub-FSMs are reset by the same signal.
- start in IDLE at cycle n -> busy=1 and state INIT_GO at n+1, init_start=1 at n+1 only.
- X_finish at cycle n in X_WAIT -> next X_GO at n+1, its start pulse at n+1.
- dec_finish coinciding with final dec_wren: that byte is counted/checked before CHECK.
- CHECK and NEXT_KEY take one cycle each; per-key overhead = 8 cycles plus sub-FSM time.
- busy=1 in every state except IDLE, FOUND, EXHAUSTED.
- start while busy: ignored.

## Structure
- Package rc4_pkg: state enum, owner enum (NONE/INIT/KSA/DEC), constants ASCII_LO=8'h61, ASCII_HI=8'h7A, ASCII_SPACE=8'h20, S_ADDR_W=8.
- One sub-module: rc4_s_ram_arbiter (owner-select mux of three address/data/wren triplets onto one port, wren masking).

## Test plan
- Stub FSMs finish after 3 cycles; dec writes 32 bytes 8'h61 -> found=1, found_key=KEY_MIN, exactly one start pulse per phase.
- KEY_MIN=0, stub bytes all 8'h41 except key 5 -> found_key=24'h000005, five NEXT_KEY passes.
- KEY_MAX=24'h000003, all bytes 8'h7B -> exhausted=1 after 4 passes, found=0, key=3.
- Decrypt stub writes only 31 valid bytes -> pass rejected, key increments.
- Owner check: ksa_s_wren=1 during INIT_WAIT -> s_wren follows init only; s_wren=0 in CHECK.
- Assert reset during KSA_WAIT -> next cycle IDLE, key=KEY_MIN, all outputs at reset values; start then restarts from INIT_GO.
